simon_stream_ctrl: RTL and testbench

SIMON_STREAM_CTRL -- requirements
Module: simon_stream_ctrl

---
 rtl/simon_stream_ctrl.sv | 210 +++++++++++++++++++++
 tb/tb_simon_stream_ctrl.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/simon_stream_ctrl.sv
// Stream-side controller for a SIMON block-cipher core: key and block handshakes,
// a single result register with host backpressure, and a per-state watchdog.
module simon_stream_ctrl #(
  parameter int N       = 24,
  parameter int M       = 4,
  parameter int TIMEOUT = 1024
) (
  input  logic           clk,
  input  logic           nR,
  input  logic           key_valid,
  input  logic [M*N-1:0] key_in,
  output logic           key_ready,
  input  logic           in_valid,
  input  logic [2*N-1:0] in_data,
  input  logic           in_enc,
  output logic           in_ready,
  output logic           out_valid,
  output logic [2*N-1:0] out_data,
  input  logic           out_ready,
  output logic           core_newData,
  output logic           core_newKey,
  output logic           core_enc_dec,
  output logic           core_readData,
  output logic [2*N-1:0] core_plain,
  output logic [M*N-1:0] core_key,
  input  logic           core_ldData,
  input  logic           core_ldKey,
  input  logic           core_doneData,
  input  logic           core_doneKey,
  input  logic [2*N-1:0] core_cipher,
  output logic           key_loaded,
  output logic           busy,
  output logic           err_timeout
);

  localparam int WW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    KREQ  = 3'd1,
    KWAIT = 3'd2,
    DREQ  = 3'd3,
    DWAIT = 3'd4,
    DRESP = 3'd5,
    DREL  = 3'd6,
    ERR   = 3'd7
  } state_t;

  state_t         state_r, state_s;
  logic [WW-1:0]  wd_r, wd_s;
  logic [M*N-1:0] key_r, key_s;
  logic [2*N-1:0] plain_r, plain_s;
  logic [2*N-1:0] out_data_r, out_data_s;
  logic           enc_r, enc_s;
  logic           out_valid_r, out_valid_s;
  logic           key_loaded_r, key_loaded_s;
  logic           err_r, err_s;
  logic           count_s;
  logic           key_ready_r, in_ready_r, busy_r;
  logic           new_key_r, new_data_r, read_data_r;

  // Next-state, datapath capture and watchdog decisions.
  always_comb begin
    state_s      = state_r;
    wd_s         = wd_r;
    key_s        = key_r;
    plain_s      = plain_r;
    enc_s        = enc_r;
    out_data_s   = out_data_r;
    key_loaded_s = key_loaded_r;
    err_s        = err_r;
    count_s      = 1'b0;
    if (out_valid_r && out_ready) begin
      out_valid_s = 1'b0;
    end else begin
      out_valid_s = out_valid_r;
    end
    case (state_r)
      IDLE: begin
        // key_ready_r is low on the first edge after reset, so nothing moves then
        if (key_valid && key_ready_r) begin
          key_s        = key_in;
          key_loaded_s = 1'b0;
          state_s      = KREQ;
        end else if (in_valid && in_ready) begin
          plain_s = in_data;
          enc_s   = in_enc;
          state_s = DREQ;
        end else begin
          state_s = IDLE;
        end
      end
      KREQ: begin
        count_s = 1'b1;
        if (core_ldKey) state_s = KWAIT;
        else            state_s = KREQ;
      end
      KWAIT: begin
        count_s = 1'b1;
        if (core_doneKey) begin
          key_loaded_s = 1'b1;
          state_s      = IDLE;
        end else begin
          state_s = KWAIT;
        end
      end
      DREQ: begin
        count_s = 1'b1;
        if (core_ldData) state_s = DWAIT;
        else             state_s = DREQ;
      end
      DWAIT: begin
        // A full result register holds the core off and pauses the watchdog
        if (out_valid_r) begin
          count_s = 1'b0;
          state_s = DWAIT;
        end else if (core_doneData) begin
          out_data_s  = core_cipher;
          out_valid_s = 1'b1;
          state_s     = DRESP;
        end else begin
          count_s = 1'b1;
          state_s = DWAIT;
        end
      end
      DRESP: begin
        count_s = 1'b1;
        if (!core_doneData) state_s = DREL;
        else                state_s = DRESP;
      end
      DREL: begin
        state_s = IDLE;
      end
      ERR: begin
        key_loaded_s = 1'b0;
        err_s        = 1'b1;
        state_s      = ERR;
      end
      default: begin
        key_loaded_s = 1'b0;
        err_s        = 1'b1;
        state_s      = ERR;
      end
    endcase
    if (state_s != state_r) begin
      wd_s = '0;
    end else if (count_s && (wd_r == WW'(TIMEOUT - 1))) begin
      state_s      = ERR;
      key_loaded_s = 1'b0;
      err_s        = 1'b1;
      wd_s         = '0;
    end else if (count_s) begin
      wd_s = wd_r + WW'(1);
    end else begin
      wd_s = wd_r;
    end
  end

  // State, datapath and registered output flags.
  always_ff @(posedge clk or negedge nR) begin
    if (!nR) begin
      state_r      <= IDLE;
      wd_r         <= '0;
      key_r        <= '0;
      plain_r      <= '0;
      enc_r        <= 1'b0;
      out_data_r   <= '0;
      out_valid_r  <= 1'b0;
      key_loaded_r <= 1'b0;
      err_r        <= 1'b0;
      key_ready_r  <= 1'b0;
      in_ready_r   <= 1'b0;
      busy_r       <= 1'b0;
      new_key_r    <= 1'b0;
      new_data_r   <= 1'b0;
      read_data_r  <= 1'b0;
    end else begin
      state_r      <= state_s;
      wd_r         <= wd_s;
      key_r        <= key_s;
      plain_r      <= plain_s;
      enc_r        <= enc_s;
      out_data_r   <= out_data_s;
      out_valid_r  <= out_valid_s;
      key_loaded_r <= key_loaded_s;
      err_r        <= err_s;
      key_ready_r  <= (state_s == IDLE);
      in_ready_r   <= (state_s == IDLE) && key_loaded_s;
      busy_r       <= (state_s != IDLE);
      new_key_r    <= (state_s == KREQ);
      new_data_r   <= (state_s == DREQ);
      read_data_r  <= (state_s == DRESP);
    end
  end

  assign key_ready     = key_ready_r;
  assign in_ready      = in_ready_r & ~key_valid;
  assign out_valid     = out_valid_r;
  assign out_data      = out_data_r;
  assign core_newData  = new_data_r;
  assign core_newKey   = new_key_r;
  assign core_enc_dec  = enc_r;
  assign core_readData = read_data_r;
  assign core_plain    = plain_r;
  assign core_key      = key_r;
  assign key_loaded    = key_loaded_r;
  assign busy          = busy_r;
  assign err_timeout   = err_r;

endmodule

// File: tb/tb_simon_stream_ctrl.sv
// Directed bench for simon_stream_ctrl driving a table-driven stand-in for the SIMON 48/96 core.
module tb_simon_stream_ctrl;

  localparam logic [95:0] K0 = 96'h1A1918_121110_0A0908_020100;
  localparam logic [47:0] P0 = 48'h72696320646E;
  localparam logic [47:0] C0 = 48'h6E06A5ACF156;

  logic        clk = 1'b0;
  logic        nR = 1'b0;
  logic        key_valid = 1'b0;
  logic [95:0] key_in = 96'd0;
  logic        key_ready;
  logic        in_valid = 1'b0;
  logic [47:0] in_data = 48'd0;
  logic        in_enc = 1'b0;
  logic        in_ready;
  logic        out_valid;
  logic [47:0] out_data;
  logic        out_ready = 1'b0;
  logic        core_newData, core_newKey, core_enc_dec, core_readData;
  logic [47:0] core_plain;
  logic [95:0] core_key;
  logic        core_ldData, core_ldKey, core_doneData, core_doneKey;
  logic [47:0] core_cipher;
  logic        key_loaded, busy, err_timeout;

  int passes = 0;
  int total  = 0;
  logic data_en = 1'b1;

  simon_stream_ctrl #(.N(24), .M(4), .TIMEOUT(16)) dut (
    .clk(clk), .nR(nR),
    .key_valid(key_valid), .key_in(key_in), .key_ready(key_ready),
    .in_valid(in_valid), .in_data(in_data), .in_enc(in_enc), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .core_newData(core_newData), .core_newKey(core_newKey), .core_enc_dec(core_enc_dec),
    .core_readData(core_readData), .core_plain(core_plain), .core_key(core_key),
    .core_ldData(core_ldData), .core_ldKey(core_ldKey), .core_doneData(core_doneData),
    .core_doneKey(core_doneKey), .core_cipher(core_cipher),
    .key_loaded(key_loaded), .busy(busy), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  // Core stand-in: known SIMON 48/96 vector pair, otherwise a simple keyed XOR
  function automatic logic [47:0] stub(input logic [95:0] k, input logic [47:0] b, input logic e);
    if (k == K0 && e && b == P0)       return C0;
    else if (k == K0 && !e && b == C0) return P0;
    else                               return b ^ k[47:0] ^ {48{e}};
  endfunction

  logic        kbusy, dbusy, denc;
  logic [2:0]  kcnt, dcnt;
  logic [47:0] dblk;
  logic [95:0] dkey;

  // Reactive core model: load pulses, fixed latency, result held until acknowledged.
  always @(posedge clk or negedge nR) begin
    if (!nR) begin
      core_ldKey <= 1'b0; core_ldData <= 1'b0; core_doneKey <= 1'b0; core_doneData <= 1'b0;
      core_cipher <= 48'd0; kbusy <= 1'b0; dbusy <= 1'b0; kcnt <= 3'd0; dcnt <= 3'd0;
      dblk <= 48'd0; dkey <= 96'd0; denc <= 1'b0;
    end else begin
      core_ldKey <= 1'b0; core_ldData <= 1'b0; core_doneKey <= 1'b0;
      if (core_newKey && !kbusy) begin
        core_ldKey <= 1'b1; kbusy <= 1'b1; kcnt <= 3'd3;
      end else if (kbusy) begin
        if (kcnt == 3'd0) begin core_doneKey <= 1'b1; kbusy <= 1'b0; end
        else kcnt <= kcnt - 3'd1;
      end
      if (core_newData && !dbusy && data_en) begin
        core_ldData <= 1'b1; dbusy <= 1'b1; dcnt <= 3'd2;
        dblk <= core_plain; denc <= core_enc_dec; dkey <= core_key;
      end else if (dbusy && !core_doneData) begin
        if (dcnt == 3'd0) begin core_cipher <= stub(dkey, dblk, denc); core_doneData <= 1'b1; end
        else dcnt <= dcnt - 3'd1;
      end else if (core_doneData && core_readData) begin
        core_doneData <= 1'b0; dbusy <= 1'b0;
      end
    end
  end

  task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic wait_out(input string tag);
    int n = 0;
    while (!out_valid && n < 100) begin @(negedge clk); n++; end
    check(tag, {95'd0, out_valid}, 96'd1);
  endtask

  task automatic send_block(input logic [47:0] b, input logic e);
    int n = 0;
    while (!in_ready && n < 100) begin @(negedge clk); n++; end
    check("send_in_ready", {95'd0, in_ready}, 96'd1);
    in_valid = 1'b1; in_data = b; in_enc = e;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic pop();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic load_key(input logic [95:0] k);
    int n = 0;
    while (!key_ready && n < 100) begin @(negedge clk); n++; end
    key_valid = 1'b1; key_in = k;
    @(negedge clk);
    key_valid = 1'b0;
    n = 0;
    while (!key_loaded && n < 100) begin @(negedge clk); n++; end
    check("key_reload", {95'd0, key_loaded}, 96'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  logic [47:0] bp_blk [5];
  logic [47:0] bp_exp [5];

  initial begin
    int n;
    int cnt;
    bp_blk[0] = 48'h000000000001; bp_exp[0] = 48'hF5F6F7FDFEFE;
    bp_blk[1] = 48'h000000000002; bp_exp[1] = 48'hF5F6F7FDFEFD;
    bp_blk[2] = 48'h000000000003; bp_exp[2] = 48'hF5F6F7FDFEFC;
    bp_blk[3] = 48'h000000000004; bp_exp[3] = 48'hF5F6F7FDFEFB;
    bp_blk[4] = 48'h000000000005; bp_exp[4] = 48'hF5F6F7FDFEFA;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_busy", {95'd0, busy}, 96'd0);
    check("rst_key_ready", {95'd0, key_ready}, 96'd0);
    check("rst_out_valid", {95'd0, out_valid}, 96'd0);
    check("rst_err", {95'd0, err_timeout}, 96'd0);
    check("rst_key_loaded", {95'd0, key_loaded}, 96'd0);
    check("rst_newKey", {95'd0, core_newKey}, 96'd0);
    check("rst_core_key", core_key, 96'd0);

    // Release with key and block offered together
    nR = 1'b1; key_valid = 1'b1; key_in = K0; in_valid = 1'b1; in_data = P0; in_enc = 1'b1;
    @(negedge clk);
    check("edge1_busy", {95'd0, busy}, 96'd0);
    check("edge1_key_ready", {95'd0, key_ready}, 96'd1);
    check("edge1_in_ready", {95'd0, in_ready}, 96'd0);
    @(negedge clk);
    check("edge2_busy", {95'd0, busy}, 96'd1);
    check("edge2_core_key", core_key, K0);
    check("edge2_newKey", {95'd0, core_newKey}, 96'd1);
    check("edge2_newData", {95'd0, core_newData}, 96'd0);
    key_valid = 1'b0; in_valid = 1'b0;
    n = 0;
    while (!key_loaded && n < 100) begin @(negedge clk); n++; end
    check("key_loaded", {95'd0, key_loaded}, 96'd1);
    check("key_newKey_low", {95'd0, core_newKey}, 96'd0);

    // Encrypt and decrypt the reference vector
    send_block(P0, 1'b1);
    check("enc_core_plain", {48'd0, core_plain}, {48'd0, P0});
    check("enc_core_mode", {95'd0, core_enc_dec}, 96'd1);
    wait_out("enc_out_valid");
    check("enc_out_data", {48'd0, out_data}, {48'd0, C0});
    check("enc_key_loaded", {95'd0, key_loaded}, 96'd1);
    pop();
    check("enc_popped", {95'd0, out_valid}, 96'd0);
    send_block(C0, 1'b0);
    check("dec_core_mode", {95'd0, core_enc_dec}, 96'd0);
    wait_out("dec_out_valid");
    check("dec_out_data", {48'd0, out_data}, {48'd0, P0});
    pop();

    // Backpressure: second result parks in DWAIT while the first is unread
    send_block(bp_blk[0], 1'b1);
    wait_out("bp_first_valid");
    send_block(bp_blk[1], 1'b1);
    repeat (25) @(negedge clk);
    check("bp_readData_low", {95'd0, core_readData}, 96'd0);
    check("bp_busy", {95'd0, busy}, 96'd1);
    check("bp_in_ready", {95'd0, in_ready}, 96'd0);
    check("bp_no_timeout", {95'd0, err_timeout}, 96'd0);
    check("bp_data_held", {48'd0, out_data}, {48'd0, bp_exp[0]});
    for (int i = 0; i < 5; i++) begin
      wait_out("bp_valid");
      check("bp_data", {48'd0, out_data}, {48'd0, bp_exp[i]});
      pop();
      if (i + 2 < 5) send_block(bp_blk[i + 2], 1'b1);
    end

    // Asynchronous reset in the middle of the result handshake
    send_block(48'h0000000000AA, 1'b1);
    n = 0;
    while (!core_readData && n < 100) begin @(negedge clk); n++; end
    check("dresp_reached", {95'd0, core_readData}, 96'd1);
    nR = 1'b0;
    #1;
    check("arst_readData", {95'd0, core_readData}, 96'd0);
    check("arst_out_valid", {95'd0, out_valid}, 96'd0);
    check("arst_out_data", {48'd0, out_data}, 96'd0);
    check("arst_key_loaded", {95'd0, key_loaded}, 96'd0);
    check("arst_busy", {95'd0, busy}, 96'd0);
    check("arst_core_plain", {48'd0, core_plain}, 96'd0);
    @(negedge clk);
    nR = 1'b1; in_valid = 1'b1; in_data = P0; in_enc = 1'b1;
    repeat (3) @(negedge clk);
    check("nokey_in_ready", {95'd0, in_ready}, 96'd0);
    check("nokey_busy", {95'd0, busy}, 96'd0);
    in_valid = 1'b0;

    // Watchdog: core never loads the block
    load_key(K0);
    data_en = 1'b0;
    send_block(P0, 1'b1);
    cnt = 0; n = 0;
    while (!err_timeout && n < 100) begin
      if (core_newData) cnt++;
      @(negedge clk);
      n++;
    end
    check("to_dreq_cycles", 96'(cnt), 96'd16);
    check("to_err", {95'd0, err_timeout}, 96'd1);
    check("to_newData", {95'd0, core_newData}, 96'd0);
    check("to_key_loaded", {95'd0, key_loaded}, 96'd0);
    check("to_busy", {95'd0, busy}, 96'd1);
    key_valid = 1'b1; key_in = K0; in_valid = 1'b1;
    repeat (5) @(negedge clk);
    check("err_sticky", {95'd0, err_timeout}, 96'd1);
    check("err_key_ready", {95'd0, key_ready}, 96'd0);
    check("err_in_ready", {95'd0, in_ready}, 96'd0);
    check("err_newKey", {95'd0, core_newKey}, 96'd0);
    nR = 1'b0; key_valid = 1'b0; in_valid = 1'b0;
    #1;
    check("err_cleared", {95'd0, err_timeout}, 96'd0);
    @(negedge clk);
    nR = 1'b1; data_en = 1'b1;
    repeat (2) @(negedge clk);
    check("recover_busy", {95'd0, busy}, 96'd0);
    check("recover_key_ready", {95'd0, key_ready}, 96'd1);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
